axis_packet_sink: RTL



---
 rtl/axis_sink_pkg.sv | 14 +
 rtl/axis_sink_stats.sv | 40 ++++
 rtl/axis_packet_sink.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/axis_sink_pkg.sv
// Shared types and constants for the axis_packet_sink slice.
// The optional error-capture outputs are enabled by AXIS_SINK_ERR_CAPTURE_EN.
package axis_sink_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRecv   = 2'd1,
        StDrain  = 2'd2,
        StReport = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_EXPECTED = 32'hDEADBEEF;

endpackage

// File: rtl/axis_sink_stats.sv
// Running packet statistics: wrapping packet counter and saturating error counter.
module axis_sink_stats #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             report_i,
    input  logic             pkt_err_i,
    output logic [CNT_W-1:0] pkt_count_o,
    output logic [CNT_W-1:0] err_count_o
);

    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        if (report_i) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
            if (pkt_err_i && (err_count_q != {CNT_W{1'b1}})) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pkt_count_o = pkt_count_q;
    assign err_count_o = err_count_q;

endmodule

// File: rtl/axis_packet_sink.sv
// AXI4-Stream packet sink: checks beat data, measures packet length, reports status.
// Define AXIS_SINK_ERR_CAPTURE_EN to add the err_data/err_idx first-mismatch outputs.
module axis_packet_sink
    import axis_sink_pkg::*;
#(
    parameter int unsigned       DATA_W        = 32,
    parameter logic [DATA_W-1:0] EXPECTED_DATA = DATA_W'(DEFAULT_EXPECTED),
    parameter int unsigned       MAX_BEATS     = 16,
    parameter int unsigned       CNT_W         = 16,
    localparam int unsigned      LEN_W         = $clog2(MAX_BEATS + 1)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              hold,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_err,
    output logic [CNT_W-1:0]  pkt_count,
`ifdef AXIS_SINK_ERR_CAPTURE_EN
    output logic [DATA_W-1:0] err_data,
    output logic [LEN_W-1:0]  err_idx,
`endif
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BEATS);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             data_err_q, data_err_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic             pkt_err_q, pkt_err_d;
    logic             pkt_done_q, pkt_done_d;

    logic             accept;
    logic             mismatch;
    logic [LEN_W-1:0] beat_inc;

    assign s_axis_tready = !areset && !hold && (state_q != StReport);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign mismatch      = (s_axis_tdata != EXPECTED_DATA);
    assign beat_inc      = (beat_cnt_q == MaxLen) ? MaxLen : beat_cnt_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        data_err_d = data_err_q;
        ovf_d      = ovf_q;
        pkt_len_d  = pkt_len_q;
        pkt_err_d  = pkt_err_q;
        pkt_done_d = 1'b0;

        unique case (state_q)
            StIdle, StRecv: begin
                if (accept) begin
                    beat_cnt_d = beat_inc;
                    data_err_d = data_err_q | mismatch;
                    if (s_axis_tlast) begin
                        state_d = StReport;
                    end else if (beat_inc == MaxLen) begin
                        state_d = StDrain;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StDrain: begin
                if (accept) begin
                    data_err_d = data_err_q | mismatch;
                    if (s_axis_tlast) begin
                        state_d = StReport;
                    end
                end
            end
            StReport: begin
                state_d    = StIdle;
                beat_cnt_d = '0;
                data_err_d = 1'b0;
                ovf_d      = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Status is captured on the tlast beat so it is already valid while pkt_done is high.
        if (accept && s_axis_tlast) begin
            pkt_len_d  = beat_cnt_d;
            pkt_err_d  = data_err_d | ovf_d;
            pkt_done_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            data_err_q <= 1'b0;
            ovf_q      <= 1'b0;
            pkt_len_q  <= '0;
            pkt_err_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            data_err_q <= data_err_d;
            ovf_q      <= ovf_d;
            pkt_len_q  <= pkt_len_d;
            pkt_err_q  <= pkt_err_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign pkt_done = pkt_done_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_err  = pkt_err_q;

`ifdef AXIS_SINK_ERR_CAPTURE_EN
    logic [DATA_W-1:0] first_data_q, first_data_d;
    logic [LEN_W-1:0]  first_idx_q, first_idx_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;
    logic [LEN_W-1:0]  err_idx_q, err_idx_d;

    // beat_cnt_q is the 0-based index of the current beat; it sticks at MAX_BEATS in drain.
    always_comb begin
        first_data_d = first_data_q;
        first_idx_d  = first_idx_q;
        err_data_d   = err_data_q;
        err_idx_d    = err_idx_q;
        if (accept && mismatch && !data_err_q) begin
            first_data_d = s_axis_tdata;
            first_idx_d  = beat_cnt_q;
        end
        if ((state_q == StReport) && data_err_q) begin
            err_data_d = first_data_q;
            err_idx_d  = first_idx_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            first_data_q <= '0;
            first_idx_q  <= '0;
            err_data_q   <= '0;
            err_idx_q    <= '0;
        end else begin
            first_data_q <= first_data_d;
            first_idx_q  <= first_idx_d;
            err_data_q   <= err_data_d;
            err_idx_q    <= err_idx_d;
        end
    end

    assign err_data = err_data_q;
    assign err_idx  = err_idx_q;
`endif

    axis_sink_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk_i       (aclk),
        .rst_i       (areset),
        .report_i    (state_q == StReport),
        .pkt_err_i   (pkt_err_q),
        .pkt_count_o (pkt_count),
        .err_count_o (err_count)
    );

endmodule
